// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial two's-complement subtractor computing a - b, LSB
//             first, one bit per clock through a single full-adder slice
//             (b inverted, initial carry 1). Returns the difference plus
//             ALU-style negative / zero / carry / overflow flags.
//  Ports    : clk, reset (sync, active-high)
//             start        - request; accepted when idle or in the done cycle
//             a, b         - operands, sampled on the accepting edge only
//             busy         - high while bits are being processed
//             done         - one-cycle pulse, result valid from this cycle
//             diff         - a - b modulo 2^WIDTH
//             negative, zero, carry (no borrow), overflow (signed)
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_c;
    logic [c_CNT_W-1:0] r_cnt;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_negative;
    logic               r_zero;
    logic               r_carry;
    logic               r_overflow;

    logic               w_nb0;
    logic               w_s;
    logic               w_c_nxt;
    logic [WIDTH-1:0]   w_res_nxt;

    // One full-adder slice with the subtrahend bit inverted.
    assign w_nb0     = ~r_b[0];
    assign w_s       = r_a[0] ^ w_nb0 ^ r_c;
    assign w_c_nxt   = (r_a[0] & w_nb0) | (r_c & (r_a[0] ^ w_nb0));
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};

    assign w_last    = (r_state == c_ST_RUN) && (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_RUN;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_c        <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_diff     <= '0;
            r_negative <= 1'b0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // busy/done are flops decoded from the next state so they are
            // aligned with the state they describe and never both high.
            r_busy  <= (w_state_nxt == c_ST_RUN);
            r_done  <= (w_state_nxt == c_ST_DONE);

            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_c   <= 1'b1;
                r_cnt <= '0;
            end else if (r_state == c_ST_RUN) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_c   <= w_c_nxt;
                r_res <= w_res_nxt;
                // Wraps only on the final bit, where the value is unused.
                r_cnt <= r_cnt + 1'b1;
            end

            // Results are loaded on the edge entering DONE so they are valid
            // in the done cycle itself. r_c here is the carry into the MSB.
            if (w_last) begin
                r_diff     <= w_res_nxt;
                r_negative <= w_res_nxt[WIDTH-1];
                r_zero     <= (w_res_nxt == '0);
                r_carry    <= w_c_nxt;
                r_overflow <= r_c ^ w_c_nxt;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign diff     = r_diff;
    assign negative = r_negative;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor. Drives a WIDTH=8 and
//             a WIDTH=64 instance with directed vectors; an arithmetic model
//             predicts busy/done timing and results every cycle, and literal
//             expectations pin the model on each test case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    typedef struct packed {
        logic        n;
        logic        z;
        logic        c;
        logic        o;
        logic [63:0] d;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance
    logic        rst8, start8, d8_busy, d8_done, d8_n, d8_z, d8_c, d8_o;
    logic [7:0]  a8, b8, d8_diff;
    // 64-bit instance
    logic        rst64, start64, d64_busy, d64_done, d64_n, d64_z, d64_c, d64_o;
    logic [63:0] a64, b64, d64_diff;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst8), .start(start8), .a(a8), .b(b8),
        .busy(d8_busy), .done(d8_done), .diff(d8_diff),
        .negative(d8_n), .zero(d8_z), .carry(d8_c), .overflow(d8_o)
    );

    serial_subtractor #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset(rst64), .start(start64), .a(a64), .b(b64),
        .busy(d64_busy), .done(d64_done), .diff(d64_diff),
        .negative(d64_n), .zero(d64_z), .carry(d64_c), .overflow(d64_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Plain-arithmetic reference for a - b on a w-bit datapath.
    function automatic res_t f_sub(input logic [63:0] a, input logic [63:0] b, input int w);
        res_t        r;
        logic [63:0] mask, am, bm;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        r.d  = (am - bm) & mask;
        r.c  = (am >= bm);
        r.n  = r.d[w-1];
        r.z  = (r.d == 64'd0);
        r.o  = (am[w-1] != bm[w-1]) && (r.d[w-1] != am[w-1]);
        return r;
    endfunction

    // Model: a request taken while no operation is outstanding completes
    // WIDTH cycles later; results appear with the done pulse and then hold.
    int   m8_left = 0;
    bit   m8_done = 1'b0;
    res_t m8_e    = '0;
    res_t m8_p    = '0;
    always @(posedge clk) begin
        if (rst8) begin
            m8_left <= 0;
            m8_done <= 1'b0;
            m8_e    <= '0;
        end else if (m8_left > 0) begin
            m8_left <= m8_left - 1;
            m8_done <= (m8_left == 1);
            if (m8_left == 1) m8_e <= m8_p;
        end else begin
            m8_done <= 1'b0;
            if (start8) begin
                m8_p    <= f_sub({56'd0, a8}, {56'd0, b8}, 8);
                m8_left <= 8;
            end
        end
    end

    int   m64_left = 0;
    bit   m64_done = 1'b0;
    res_t m64_e    = '0;
    res_t m64_p    = '0;
    always @(posedge clk) begin
        if (rst64) begin
            m64_left <= 0;
            m64_done <= 1'b0;
            m64_e    <= '0;
        end else if (m64_left > 0) begin
            m64_left <= m64_left - 1;
            m64_done <= (m64_left == 1);
            if (m64_left == 1) m64_e <= m64_p;
        end else begin
            m64_done <= 1'b0;
            if (start64) begin
                m64_p    <= f_sub(a64, b64, 64);
                m64_left <= 64;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy8", {63'd0, d8_busy}, {63'd0, (m8_left != 0)});
            cmp("done8", {63'd0, d8_done}, {63'd0, m8_done});
            cmp("diff8", {56'd0, d8_diff}, m8_e.d);
            cmp("neg8",  {63'd0, d8_n}, {63'd0, m8_e.n});
            cmp("zero8", {63'd0, d8_z}, {63'd0, m8_e.z});
            cmp("cry8",  {63'd0, d8_c}, {63'd0, m8_e.c});
            cmp("ovf8",  {63'd0, d8_o}, {63'd0, m8_e.o});
            cmp("busy64", {63'd0, d64_busy}, {63'd0, (m64_left != 0)});
            cmp("done64", {63'd0, d64_done}, {63'd0, m64_done});
            cmp("diff64", d64_diff, m64_e.d);
            cmp("neg64",  {63'd0, d64_n}, {63'd0, m64_e.n});
            cmp("zero64", {63'd0, d64_z}, {63'd0, m64_e.z});
            cmp("cry64",  {63'd0, d64_c}, {63'd0, m64_e.c});
            cmp("ovf64",  {63'd0, d64_o}, {63'd0, m64_e.o});
        end
    end

    // One 8-bit operation with a single-cycle start and literal expectations.
    task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input bit en, input bit ez,
                        input bit ec, input bit eo);
        int acc;
        int busy_n;
        bit ok;
        @(posedge clk); #2;
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        acc    = cyc;
        busy_n = 0;
        ok     = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (d8_done) ok = 1'b1;
            else if (d8_busy) busy_n++;
        end
        cmp({nm, "_done_seen"}, {63'd0, ok}, 64'd1);
        cmp({nm, "_latency"}, 64'(cyc - acc), 64'd8);
        cmp({nm, "_busy_cycles"}, 64'(busy_n), 64'd8);
        cmp({nm, "_diff"}, {56'd0, d8_diff}, {56'd0, ed});
        cmp({nm, "_flags_nzco"}, {60'd0, d8_n, d8_z, d8_c, d8_o}, {60'd0, en, ez, ec, eo});
    endtask

    initial begin : stim
        int  acc;
        int  t1;
        int  dn;
        bit  ok;
        rst8 = 1'b1; rst64 = 1'b1;
        start8 = 1'b0; start64 = 1'b0;
        a8 = '0; b8 = '0; a64 = '0; b64 = '0;

        @(posedge clk);
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        cmp("rst_outputs8", {54'd0, d8_busy, d8_done, d8_diff}, 64'd0);
        cmp("rst_flags8", {60'd0, d8_n, d8_z, d8_c, d8_o}, 64'd0);
        cmp("rst_diff64", d64_diff, 64'd0);
        @(posedge clk); #2;
        rst8 = 1'b0; rst64 = 1'b0;

        run8("basic",  8'd5,   8'd3,   8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
        run8("borrow", 8'd3,   8'd5,   8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        run8("ovf",    8'h80,  8'h01,  8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
        run8("zero",   8'h2A,  8'h2A,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Second start while busy must be ignored.
        @(posedge clk); #2;
        a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        acc = cyc;
        repeat (2) @(posedge clk);
        #2; a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (d8_done) ok = 1'b1;
        end
        cmp("ignore_done_seen", {63'd0, ok}, 64'd1);
        cmp("ignore_latency", 64'(cyc - acc), 64'd8);
        cmp("ignore_diff", {56'd0, d8_diff}, 64'h05);
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (d8_done) dn++;
        end
        cmp("ignore_extra_done", 64'(dn), 64'd0);

        // Reset after four RUN cycles.
        @(posedge clk); #2;
        a8 = 8'd7; b8 = 8'd2; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst8 = 1'b1;
        @(posedge clk); #2;
        rst8 = 1'b0;
        @(negedge clk);
        cmp("midrst_busy_done", {62'd0, d8_busy, d8_done}, 64'd0);
        cmp("midrst_diff", {56'd0, d8_diff}, 64'd0);
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (d8_done) dn++;
        end
        cmp("midrst_no_done", 64'(dn), 64'd0);
        run8("after_rst", 8'd7, 8'd2, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full width, start held high through DONE for back-to-back operation.
        @(posedge clk); #2;
        a64 = 64'd0; b64 = 64'd1; start64 = 1'b1;
        @(posedge clk); #2;
        acc = cyc;
        a64 = 64'h8000_0000_0000_0000; b64 = 64'd1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (d64_done) ok = 1'b1;
        end
        t1 = cyc;
        cmp("w64_first_done_seen", {63'd0, ok}, 64'd1);
        cmp("w64_first_latency", 64'(t1 - acc), 64'd64);
        cmp("w64_first_diff", d64_diff, 64'hFFFF_FFFF_FFFF_FFFF);
        cmp("w64_first_flags_nzco", {60'd0, d64_n, d64_z, d64_c, d64_o}, 64'b1000);
        @(posedge clk); #2;
        start64 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (d64_done) ok = 1'b1;
        end
        cmp("w64_second_done_seen", {63'd0, ok}, 64'd1);
        cmp("w64_b2b_spacing", 64'(cyc - t1), 64'd65);
        cmp("w64_second_diff", d64_diff, 64'h7FFF_FFFF_FFFF_FFFF);
        cmp("w64_second_flags_nzco", {60'd0, d64_n, d64_z, d64_c, d64_o}, 64'b0011);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
